fleet_register: RTL and testbench
=================================

# fleet_register

Parametrised fleet register for the battleship datapath. It holds the cell-occupancy mask of up to `N_SHIPS` ships on a `CELLS`-cell board. It also holds a per-ship hit mask and resolves shots with a registered hit/sunk result. It sits between the placement FSM and the turn controller and provides per-ship liveness, the alive count and the fleet-destroyed flag.

## Interface
- `N_SHIPS`, 5, number of ship slots.
- `CELLS`, 25, board cells (bit i = cell i).
- `IDX_W`, `$clog2(N_SHIPS)`, derived, ship index width.
- `CELL_W`, `$clog2(CELLS)`, derived, cell index width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `place_en` in 1: write `place_mask` into slot `place_id`.
- `place_id` in `IDX_W`: target slot.
- `place_mask` in `CELLS`: new occupancy; all-zero removes the ship.
- `place_err` out 1: registered one-cycle pulse when a placement is rejected.
- `shot_valid` in 1: shot request.
- `shot_cell` in `CELL_W`: target cell.
- `shot_ready` out 1: `~place_en`; a shot is accepted when `shot_valid & shot_ready`.
- `result_valid` out 1: one-cycle pulse, the result of the accepted shot.
- `result_hit` out 1: shot landed on a cell of a live ship that was not already hit.
- `result_repeat` out 1: shot landed on an already-hit cell.
- `result_sunk` out 1: this shot completed a ship.
- `result_id` out `IDX_W`: ship hit; 0 on a miss.
- `occupancy` out `CELLS`: OR of all ship masks.
- `ship_alive` out `N_SHIPS`: slot nonzero and not all cells hit.
- `alive_count` out `IDX_W+1`: popcount of `ship_alive`.
- `fleet_dead` out 1: `placed_any & (alive_count==0)`.

## Operation
- State per slot: `mask[i]` (`CELLS` bits) and `hits[i]` (`CELLS` bits). Global state: `placed_any`.
- Placement, on `place_en`:
  - Accept if `place_mask & mask[j]` is 0 for every j ≠ `place_id`, and `place_id < N_SHIPS`.
  - On accept: `mask[place_id] <= place_mask`, `hits[place_id] <= 0`, `placed_any <= 1` if `place_mask` is nonzero.
  - On reject: no state change and `place_err` pulses.
- Shot, accepted only while `place_en` is low:
  - Index check: `shot_cell >= CELLS` is a miss. All result flags are 0 except `result_valid`.
  - Locate owner: slot k with `mask[k][shot_cell]`. Masks are disjoint by construction, so there is at most one owner.
  - No owner: miss.
  - Owner with the hit bit already set: `result_repeat=1`, `result_hit=0`, no state change.
  - Otherwise: set `hits[k][shot_cell]`, `result_hit=1`, `result_id=k`. Set `result_sunk=1` iff the updated hits equal `mask[k]`.
- Liveness: `ship_alive[i] = |mask[i] & (hits[i] != mask[i])`. This is combinational from the registers.
- Re-placing an existing slot is allowed. It clears that ship's hits.
- Removing every ship does not clear `placed_any`. Only `rst` clears it.

## Timing
- Reset is asynchronous and immediate. All `mask`, `hits`, `placed_any` and all outputs go to 0: `fleet_dead=0`, `alive_count=0`, `occupancy=0`.
- Shot latency: a shot accepted at edge n produces `result_*` valid during the cycle after edge n. `result_valid` is high for exactly 1 cycle.
- Back-to-back shots are supported, one per cycle. A shot sees the hits of all earlier shots, including the one accepted in the immediately preceding cycle.
- `place_err` asserts the cycle after the offending `place_en`, for 1 cycle.
- `ship_alive`, `alive_count`, `fleet_dead` and `occupancy` reflect the register state, so they update 1 cycle after the causing edge.
- `place_en` and `shot_valid` in the same cycle: placement executes, `shot_ready=0`, and the shot is not accepted. The requester must hold `shot_valid`.
- `rst` asserted mid-operation: any pending result is dropped and no `result_valid` follows.

## Test plan
- Reset, then place ship 0 = cells {0,1,2} and ship 1 = {5,6}. Expect `occupancy=0x67`, `alive_count=2`, `fleet_dead=0`, no `place_err`.
- Place ship 2 = {2,3} over ship 0. Expect a `place_err` pulse one cycle later and `occupancy` unchanged.
- Shots at 5, 6 back-to-back:
  - Shot at 5: `result_hit=1`, `result_id=1`, `sunk=0`.
  - Shot at 6: `result_hit=1`, `sunk=1`.
  - After: `ship_alive=0b00001`, `alive_count=1`.
- Shots at 6 (repeat), then 24 (miss), then 30 (out of range):
  - Shot at 6: `result_repeat=1`.
  - Shots at 24 and 30: `result_valid=1` with all other flags 0.
- Sink ship 0 with cells 0, 1, 2. Expect `result_sunk` on cell 2 and `fleet_dead=1` the next cycle. Then re-place ship 0 = {0,1}: expect `fleet_dead=0` and `alive_count=1`.
- Raise `place_en` and `shot_valid` in the same cycle: the shot is deferred with `shot_ready=0`. Assert `rst` asynchronously between clock edges: all outputs go to 0 immediately.

Source files
------------

// File: rtl/fleet_register_if.sv
// Bus bundle between the fleet register and its users: placement port,
// shot request/result port and the fleet status outputs.
interface fleet_register_if #(
    parameter int N_SHIPS = 5,
    parameter int CELLS   = 25
) ();
    localparam int IDX_W  = $clog2(N_SHIPS);
    localparam int CELL_W = $clog2(CELLS);

    logic                place_en;
    logic [IDX_W-1:0]    place_id;
    logic [CELLS-1:0]    place_mask;
    logic                place_err;

    logic                shot_valid;
    logic [CELL_W-1:0]   shot_cell;
    logic                shot_ready;

    logic                result_valid;
    logic                result_hit;
    logic                result_repeat;
    logic                result_sunk;
    logic [IDX_W-1:0]    result_id;

    logic [CELLS-1:0]    occupancy;
    logic [N_SHIPS-1:0]  ship_alive;
    logic [IDX_W:0]      alive_count;
    logic                fleet_dead;

    modport master (
        output place_en, place_id, place_mask, shot_valid, shot_cell,
        input  place_err, shot_ready, result_valid, result_hit, result_repeat,
               result_sunk, result_id, occupancy, ship_alive, alive_count, fleet_dead
    );

    modport slave (
        input  place_en, place_id, place_mask, shot_valid, shot_cell,
        output place_err, shot_ready, result_valid, result_hit, result_repeat,
               result_sunk, result_id, occupancy, ship_alive, alive_count, fleet_dead
    );
endinterface

// File: rtl/fleet_register.sv
// Fleet register: per-ship occupancy and hit masks, placement with overlap
// rejection, registered shot resolution and fleet liveness status.
module fleet_register #(
    parameter int N_SHIPS = 5,
    parameter int CELLS   = 25
) (
    input logic             clk,
    input logic             rst,
    fleet_register_if.slave bus
);
    localparam int IDX_W  = $clog2(N_SHIPS);
    localparam int CELL_W = $clog2(CELLS);
    localparam logic [IDX_W:0]  SHIPS_LIM = (IDX_W + 1)'(N_SHIPS);
    localparam logic [CELL_W:0] CELLS_LIM = (CELL_W + 1)'(CELLS);

    logic [CELLS-1:0]   mask [N_SHIPS];
    logic [CELLS-1:0]   hits [N_SHIPS];
    logic               placed_any;

    logic               place_ok;
    logic               shot_take;
    logic [CELLS-1:0]   cell_sel;
    logic               owner_found;
    logic [IDX_W-1:0]   owner;
    logic               owner_hit;
    logic               owner_sunk;

    logic [CELLS-1:0]   occ;
    logic [N_SHIPS-1:0] alive;
    logic [IDX_W:0]     cnt;

    // Placement shows ready-gating: a placement always wins over a shot.
    assign bus.shot_ready = ~bus.place_en;
    assign shot_take      = bus.shot_valid & ~bus.place_en;

    // Placement is legal when the slot exists and the new mask overlaps no other ship.
    always_comb begin
        place_ok = ({1'b0, bus.place_id} < SHIPS_LIM);
        for (int unsigned j = 0; j < N_SHIPS; j++) begin
            if (bus.place_id != IDX_W'(j) && |(bus.place_mask & mask[j])) begin
                place_ok = 1'b0;
            end
        end
    end

    // Decode the shot cell and find its (unique) owning ship and hit status.
    always_comb begin
        cell_sel    = ({1'b0, bus.shot_cell} < CELLS_LIM) ? (CELLS'(1) << bus.shot_cell) : '0;
        owner_found = 1'b0;
        owner       = '0;
        owner_hit   = 1'b0;
        owner_sunk  = 1'b0;
        for (int unsigned k = 0; k < N_SHIPS; k++) begin
            if (|(mask[k] & cell_sel)) begin
                owner_found = 1'b1;
                owner       = IDX_W'(k);
                owner_hit   = |(hits[k] & cell_sel);
                owner_sunk  = ((hits[k] | cell_sel) == mask[k]);
            end
        end
    end

    // Board state: placement writes a slot and clears its hits; a fresh hit sets one bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_SHIPS; i++) begin
                mask[i] <= '0;
                hits[i] <= '0;
            end
            placed_any <= 1'b0;
        end else if (bus.place_en) begin
            if (place_ok) begin
                for (int unsigned i = 0; i < N_SHIPS; i++) begin
                    if (bus.place_id == IDX_W'(i)) begin
                        mask[i] <= bus.place_mask;
                        hits[i] <= '0;
                    end
                end
                if (|bus.place_mask) begin
                    placed_any <= 1'b1;
                end
            end
        end else if (shot_take && owner_found && !owner_hit) begin
            for (int unsigned i = 0; i < N_SHIPS; i++) begin
                if (owner == IDX_W'(i)) begin
                    hits[i] <= hits[i] | cell_sel;
                end
            end
        end
    end

    // Registered one-cycle result and placement-error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.place_err     <= 1'b0;
            bus.result_valid  <= 1'b0;
            bus.result_hit    <= 1'b0;
            bus.result_repeat <= 1'b0;
            bus.result_sunk   <= 1'b0;
            bus.result_id     <= '0;
        end else begin
            bus.place_err     <= bus.place_en & ~place_ok;
            bus.result_valid  <= shot_take;
            bus.result_hit    <= shot_take & owner_found & ~owner_hit;
            bus.result_repeat <= shot_take & owner_found & owner_hit;
            bus.result_sunk   <= shot_take & owner_found & ~owner_hit & owner_sunk;
            bus.result_id     <= (shot_take && owner_found) ? owner : '0;
        end
    end

    // Fleet status derived directly from the registered masks.
    always_comb begin
        occ = '0;
        cnt = '0;
        for (int unsigned i = 0; i < N_SHIPS; i++) begin
            occ      = occ | mask[i];
            alive[i] = (|mask[i]) && (hits[i] != mask[i]);
            cnt      = cnt + (IDX_W + 1)'(alive[i]);
        end
    end

    assign bus.occupancy   = occ;
    assign bus.ship_alive  = alive;
    assign bus.alive_count = cnt;
    assign bus.fleet_dead  = placed_any & (cnt == '0);
endmodule

// File: tb/tb_fleet_register.sv
// Testbench for fleet_register: directed test-plan steps followed by random
// placements/shots, checked against a cell-ownership reference model.
module tb_fleet_register;
    localparam int N_SHIPS = 5;
    localparam int CELLS   = 25;
    localparam int IDX_W   = $clog2(N_SHIPS);
    localparam int CELL_W  = $clog2(CELLS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fleet_register_if #(.N_SHIPS(N_SHIPS), .CELLS(CELLS)) bus ();
    fleet_register #(.N_SHIPS(N_SHIPS), .CELLS(CELLS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference model: owner of each cell (-1 none), per-cell hit flag,
    // ship size and number of hits taken.
    int own [CELLS];
    bit hc  [CELLS];
    int sz  [N_SHIPS];
    int nh  [N_SHIPS];
    bit placed;
    bit e_valid, e_hit, e_rep, e_sunk, e_perr;
    int e_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CELLS; c++) begin own[c] = -1; hc[c] = 0; end
        for (int s = 0; s < N_SHIPS; s++) begin sz[s] = 0; nh[s] = 0; end
        placed = 0;
        e_valid = 0; e_hit = 0; e_rep = 0; e_sunk = 0; e_perr = 0; e_id = 0;
    endtask

    task automatic model_edge();
        bit ok;
        int pid, sc, k;
        logic [CELLS-1:0] pm;
        e_valid = 0; e_hit = 0; e_rep = 0; e_sunk = 0; e_perr = 0; e_id = 0;
        pid = int'(bus.place_id);
        pm  = bus.place_mask;
        sc  = int'(bus.shot_cell);
        if (bus.place_en) begin
            ok = (pid < N_SHIPS);
            for (int c = 0; c < CELLS; c++)
                if (pm[c] && own[c] != -1 && own[c] != pid) ok = 0;
            if (!ok) e_perr = 1;
            else begin
                for (int c = 0; c < CELLS; c++)
                    if (own[c] == pid) begin own[c] = -1; hc[c] = 0; end
                sz[pid] = 0;
                nh[pid] = 0;
                for (int c = 0; c < CELLS; c++)
                    if (pm[c]) begin own[c] = pid; sz[pid]++; end
                if (pm != 0) placed = 1;
            end
        end else if (bus.shot_valid) begin
            e_valid = 1;
            if (sc < CELLS) begin
                if (own[sc] != -1) begin
                    k = own[sc];
                    e_id = k;
                    if (hc[sc]) e_rep = 1;
                    else begin
                        hc[sc] = 1;
                        nh[k]++;
                        e_hit  = 1;
                        e_sunk = (nh[k] == sz[k]);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [CELLS-1:0]   occ;
        logic [N_SHIPS-1:0] al;
        int cnt;
        occ = '0; al = '0; cnt = 0;
        for (int c = 0; c < CELLS; c++) if (own[c] != -1) occ[c] = 1'b1;
        for (int s = 0; s < N_SHIPS; s++)
            if (sz[s] > 0 && nh[s] < sz[s]) begin al[s] = 1'b1; cnt++; end
        chk("result_valid",  bus.result_valid,  e_valid);
        chk("result_hit",    bus.result_hit,    e_hit);
        chk("result_repeat", bus.result_repeat, e_rep);
        chk("result_sunk",   bus.result_sunk,   e_sunk);
        if (!e_rep) chk("result_id", bus.result_id, e_id);
        chk("place_err",     bus.place_err,     e_perr);
        chk("occupancy",     bus.occupancy,     occ);
        chk("ship_alive",    bus.ship_alive,    al);
        chk("alive_count",   bus.alive_count,   cnt);
        chk("fleet_dead",    bus.fleet_dead,    placed && cnt == 0);
    endtask

    task automatic cycle();
        #1;
        chk("shot_ready", bus.shot_ready, !bus.place_en);
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic place(input int id, input logic [CELLS-1:0] m);
        bus.place_en = 1'b1; bus.place_id = IDX_W'(id); bus.place_mask = m;
        cycle();
        bus.place_en = 1'b0;
    endtask

    task automatic shoot(input int c);
        bus.shot_valid = 1'b1; bus.shot_cell = CELL_W'(c);
        cycle();
        bus.shot_valid = 1'b0;
    endtask

    initial begin
        logic [CELLS-1:0] m;
        int nb;
        bus.place_en = 0; bus.place_id = '0; bus.place_mask = '0;
        bus.shot_valid = 0; bus.shot_cell = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset occupancy", bus.occupancy, 0);
        rst = 1'b0;

        // Two ships placed.
        place(0, 25'h7);
        place(1, 25'h60);
        chk("plan occupancy", bus.occupancy, 'h67);
        chk("plan alive_count", bus.alive_count, 2);
        chk("plan place_err low", bus.place_err, 0);

        // Overlapping placement rejected.
        place(2, 25'hC);
        chk("overlap place_err", bus.place_err, 1);
        chk("overlap occupancy", bus.occupancy, 'h67);
        cycle();
        chk("place_err one cycle", bus.place_err, 0);

        // Back-to-back shots sink ship 1.
        bus.shot_valid = 1'b1; bus.shot_cell = 5;
        cycle();
        chk("shot5 hit", bus.result_hit, 1);
        chk("shot5 id", bus.result_id, 1);
        chk("shot5 sunk", bus.result_sunk, 0);
        bus.shot_cell = 6;
        cycle();
        bus.shot_valid = 1'b0;
        chk("shot6 hit", bus.result_hit, 1);
        chk("shot6 sunk", bus.result_sunk, 1);
        chk("after sink alive", bus.ship_alive, 5'b00001);
        chk("after sink count", bus.alive_count, 1);

        // Repeat, miss, out of range.
        shoot(6);
        chk("repeat flag", bus.result_repeat, 1);
        chk("repeat hit", bus.result_hit, 0);
        shoot(24);
        chk("miss valid", bus.result_valid, 1);
        chk("miss flags", {bus.result_hit, bus.result_repeat, bus.result_sunk}, 0);
        shoot(30);
        chk("oor valid", bus.result_valid, 1);
        chk("oor flags", {bus.result_hit, bus.result_repeat, bus.result_sunk, bus.result_id}, 0);

        // Sink ship 0, fleet destroyed, then re-place.
        shoot(0);
        shoot(1);
        shoot(2);
        chk("ship0 sunk", bus.result_sunk, 1);
        chk("fleet_dead", bus.fleet_dead, 1);
        place(0, 25'h3);
        chk("replace fleet_dead", bus.fleet_dead, 0);
        chk("replace count", bus.alive_count, 1);

        // Placement and shot in the same cycle: shot deferred.
        bus.place_en = 1'b1; bus.place_id = 3; bus.place_mask = 25'h1 << 10;
        bus.shot_valid = 1'b1; bus.shot_cell = 10;
        cycle();
        chk("deferred no result", bus.result_valid, 0);
        bus.place_en = 1'b0;
        cycle();
        bus.shot_valid = 1'b0;
        chk("deferred hit", bus.result_hit, 1);
        chk("deferred id", bus.result_id, 3);

        // Asynchronous reset with a result in flight.
        shoot(0);
        chk("pre-reset valid", bus.result_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async result_valid", bus.result_valid, 0);
        chk("async result_hit", bus.result_hit, 0);
        chk("async occupancy", bus.occupancy, 0);
        chk("async alive_count", bus.alive_count, 0);
        chk("async fleet_dead", bus.fleet_dead, 0);
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Random placements and shots.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                m  = '0;
                nb = $urandom_range(0, 4);
                for (int j = 0; j < nb; j++) m[$urandom_range(0, CELLS - 1)] = 1'b1;
                bus.place_en   = 1'b1;
                bus.place_id   = IDX_W'($urandom_range(0, 7));
                bus.place_mask = m;
            end else begin
                bus.place_en = 1'b0;
            end
            bus.shot_valid = ($urandom_range(0, 3) != 0);
            bus.shot_cell  = CELL_W'($urandom_range(0, 31));
            cycle();
        end
        bus.place_en = 1'b0;
        bus.shot_valid = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
